// File: rtl/count_step_scheduler_if.sv
// Step-scheduler handshake bundle: run/direction/request inputs and the
// step strobe, acknowledges and status returned by the scheduler.
interface count_step_scheduler_if;
    logic Run;
    logic DirUp;
    logic ReqUp;
    logic ReqDn;
    logic StepEn;
    logic StepUp;
    logic AckUp;
    logic AckDn;
    logic TickDrop;
    logic Busy;

    modport master (
        output Run, DirUp, ReqUp, ReqDn,
        input  StepEn, StepUp, AckUp, AckDn, TickDrop, Busy
    );

    modport slave (
        input  Run, DirUp, ReqUp, ReqDn,
        output StepEn, StepUp, AckUp, AckDn, TickDrop, Busy
    );
endinterface

// File: rtl/count_step_scheduler.sv
// Arbitrates manual up/down step requests and a prescaled auto-run tick into
// one-cycle step strobes, with a fixed hold-off between consecutive steps.
module count_step_scheduler #(
    parameter int TICK_DIV   = 50_000_000,
    parameter int DIV_WIDTH  = 26,
    parameter int HOLDOFF    = 4,
    parameter int HOLD_WIDTH = 8
) (
    input  logic                   Clk,
    input  logic                   Rst,
    count_step_scheduler_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01,
        HOLD  = 2'b10
    } state_t;

    localparam logic [DIV_WIDTH-1:0]  DIV_MAX   = DIV_WIDTH'(TICK_DIV - 1);
    localparam logic [HOLD_WIDTH-1:0] HOLD_LOAD = HOLD_WIDTH'(HOLDOFF - 1);

    state_t                state_q, state_d;
    logic [DIV_WIDTH-1:0]  div_q, div_d;
    logic [HOLD_WIDTH-1:0] hold_q, hold_d;
    logic                  pend_q, pend_d;
    logic                  last_up_q, last_up_d;
    logic                  step_en_q, step_en_d;
    logic                  step_up_q, step_up_d;
    logic                  ack_up_q, ack_up_d;
    logic                  ack_dn_q, ack_dn_d;
    logic                  tick_drop_q, tick_drop_d;
    logic                  busy_q, busy_d;
    logic                  grant_up;
    logic                  auto_take;

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d     = state_q;
        div_d       = div_q;
        hold_d      = hold_q;
        pend_d      = pend_q;
        last_up_d   = last_up_q;
        step_en_d   = 1'b0;
        step_up_d   = 1'b0;
        ack_up_d    = 1'b0;
        ack_dn_d    = 1'b0;
        tick_drop_d = 1'b0;
        busy_d      = 1'b0;
        grant_up    = 1'b0;
        auto_take   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.ReqUp || bus.ReqDn) begin
                    // On a tie the side not granted last wins.
                    grant_up  = bus.ReqUp && (!bus.ReqDn || !last_up_q);
                    state_d   = GRANT;
                    step_en_d = 1'b1;
                    step_up_d = grant_up;
                    ack_up_d  = grant_up;
                    ack_dn_d  = !grant_up;
                    last_up_d = grant_up;
                    busy_d    = 1'b1;
                end else if (pend_q && bus.Run) begin
                    auto_take = 1'b1;
                    state_d   = GRANT;
                    step_en_d = 1'b1;
                    step_up_d = bus.DirUp;
                    busy_d    = 1'b1;
                end
            end
            GRANT: begin
                state_d = HOLD;
                hold_d  = HOLD_LOAD;
                busy_d  = 1'b1;
            end
            HOLD: begin
                if (hold_q == '0) begin
                    state_d = IDLE;
                end else begin
                    hold_d = hold_q - HOLD_WIDTH'(1);
                    busy_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A tick consumed on the same edge as a wrap leaves room for the new one.
        if (!bus.Run) begin
            div_d  = '0;
            pend_d = 1'b0;
        end else if (div_q == DIV_MAX) begin
            div_d       = '0;
            pend_d      = 1'b1;
            tick_drop_d = pend_q && !auto_take;
        end else begin
            div_d = div_q + DIV_WIDTH'(1);
            if (auto_take) pend_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q     <= IDLE;
            div_q       <= '0;
            hold_q      <= '0;
            pend_q      <= 1'b0;
            last_up_q   <= 1'b0;
            step_en_q   <= 1'b0;
            step_up_q   <= 1'b0;
            ack_up_q    <= 1'b0;
            ack_dn_q    <= 1'b0;
            tick_drop_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            hold_q      <= hold_d;
            pend_q      <= pend_d;
            last_up_q   <= last_up_d;
            step_en_q   <= step_en_d;
            step_up_q   <= step_up_d;
            ack_up_q    <= ack_up_d;
            ack_dn_q    <= ack_dn_d;
            tick_drop_q <= tick_drop_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.StepEn   = step_en_q;
    assign bus.StepUp   = step_up_q;
    assign bus.AckUp    = ack_up_q;
    assign bus.AckDn    = ack_dn_q;
    assign bus.TickDrop = tick_drop_q;
    assign bus.Busy     = busy_q;

endmodule

// File: doc/count_step_scheduler.md
# count_step_scheduler

Sequences step commands into the up/down even counter FSM. It arbitrates between two manual step requesters (up button, down button) and an internal auto-run tick from a programmable prescaler, then issues one-cycle step strobes with direction. A hold-off interval is enforced between consecutive steps. It replaces the free-running divider as the counter's only step source, so every counter transition is traceable to exactly one grant.

## Interface

- TICK_DIV, 50_000_000: Clk cycles per auto-run tick; legal range 2..2^DIV_WIDTH.
- DIV_WIDTH, 26: prescaler counter width.
- HOLDOFF, 4: cycles spent in HOLD after each grant; legal range ≥1.
- HOLD_WIDTH, 8: hold-off counter width; HOLDOFF ≤ 2^HOLD_WIDTH-1.

- Clk  in  1  system clock; all logic is on the rising edge.
- Rst  in  1  asynchronous, active-high reset.
- Run  in  1  level; enables auto-run ticking.
- DirUp  in  1  auto-run direction (1=up); sampled at grant.
- ReqUp  in  1  manual up-step request, level; held until AckUp.
- ReqDn  in  1  manual down-step request, level; held until AckDn.
- StepEn  out  1  one-cycle step strobe to the counter.
- StepUp  out  1  direction qualifier, valid while StepEn=1.
- AckUp  out  1  one-cycle grant to ReqUp; coincident with StepEn.
- AckDn  out  1  one-cycle grant to ReqDn; coincident with StepEn.
- TickDrop  out  1  one-cycle pulse when an auto tick is lost.
- Busy  out  1  high in GRANT or HOLD.

## Operation

- All outputs are registered. Reset value of all outputs: 0. Rst also clears the prescaler, tick pending, hold counter, last-grant pointer (= Dn) and state (= IDLE). Rst asserted mid-grant or mid-hold aborts immediately; no strobe completes.
- Prescaler: while Run=1 it increments each cycle. At TICK_DIV-1 it wraps to 0 and sets Pend. While Run=0 the prescaler is held at 0 and Pend is cleared.
- Drop: if Pend is already 1 at a wrap, Pend stays 1, no second tick is queued, and TickDrop pulses for one cycle.
- State machine, encoded IDLE=00, GRANT=01, HOLD=10; 11 is illegal and recovers to IDLE.
  - IDLE: if ReqUp or ReqDn is set, go to GRANT with a manual source. Otherwise, if Pend and Run are both 1, go to GRANT with the auto source and clear Pend on that edge. Otherwise stay in IDLE.
  - GRANT, one cycle: StepEn=1. StepUp is 1 for Up, 0 for Dn, and DirUp latched at the IDLE→GRANT edge for auto. The matching Ack is 1. Next state is HOLD and the hold counter loads HOLDOFF-1.
  - HOLD: decrement each cycle. At 0, go to IDLE. Requests and ticks arriving in HOLD wait; Pend keeps accumulating, with drop rules as above.
- Arbitration: manual requests beat auto. If ReqUp and ReqDn are both set, the requester not granted last wins (round robin). The pointer updates only on manual grants, and its reset value makes Up win the first tie.
- A manual grant does not clear Pend.
- A requester still holding Req after its Ack is granted again on the next IDLE, which auto-repeats at the hold-off rate. Requesters drop Req on the cycle Ack is seen to avoid this.
- Run dropping while in GRANT/HOLD does not cancel the strobe in progress.

## Timing

- Request-to-strobe latency: a request first seen high in IDLE at edge k moves the state to GRANT at edge k, with StepEn high from k to k+1.
- Step spacing: minimum spacing between StepEn pulses is HOLDOFF+2 cycles (GRANT + HOLDOFF + IDLE).
- Auto-run cadence, with Run rising before edge 0: Pend sets at edge TICK_DIV-1 and StepEn is high during cycle TICK_DIV. With an idle arbiter, the steady auto step period is exactly TICK_DIV cycles, provided TICK_DIV ≥ HOLDOFF+2.
- TickDrop occurs only when TICK_DIV < HOLDOFF+2 or manual traffic starves auto.

## Test plan

Bench parameters: TICK_DIV=8, HOLDOFF=4.

- Reset: Rst pulse mid-HOLD → all outputs 0 the same cycle; after release, first step requires a new request.
- Single manual: ReqUp high 1 cycle in IDLE → StepEn=1, StepUp=1, AckUp=1 next cycle; Busy high 5 cycles; no further StepEn.
- Tie and hold: ReqUp and ReqDn held high continuously → grants alternate Up, Dn, Up, …, StepEn every 6 cycles, with Ack matching.
- Auto-run: Run=1, DirUp=0, no manual requests → StepEn with StepUp=0 every 8 cycles, first at cycle 8; TickDrop never asserts.
- Priority and drop: Run=1 plus ReqUp held for 20 cycles → only manual grants. TickDrop pulses at the second wrap; the pending auto step issues once after ReqUp drops.
- Run toggle: Run dropped with Pend=1 → Pend cleared, no auto StepEn. Run reasserted → next tick 8 cycles later.
